// File: rtl/trail_writer.sv
// Trail memory writer: clears the whole trail RAM after reset or on request,
// and stamps a short strip perpendicular to travel behind the bike's tail
// for every accepted move.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_CLEAR | sweeping zeros over every address, one per cycle
// S_IDLE  | waiting for clear_req or an accepted move
// S_STAMP | writing the 2*HALF_WIDTH+1 strip pixels, one per cycle
module trail_writer #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int TAIL_OFFSET = 16,
    parameter int HALF_WIDTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        master_switch,
    input  logic        clear_req,
    input  logic        move_valid,
    output logic        move_ready,
    input  logic [18:0] bikeLocation_middle,
    input  logic [2:0]  bike_orient,
    input  logic [3:0]  player_color,
    output logic        trail_wren,
    output logic [18:0] trail_waddr,
    output logic [3:0]  trail_wdata,
    output logic        clear_busy,
    output logic        stamp_done
);

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_STAMP = 2'd2;

    localparam logic [18:0] ADDR_MAX = 19'(H_RES * V_RES - 1);
    localparam logic [18:0] V_OFF    = 19'(TAIL_OFFSET * H_RES);
    localparam logic [18:0] H_OFF    = 19'(TAIL_OFFSET);
    localparam logic [18:0] ROW_STEP = 19'(H_RES);
    localparam logic [18:0] BACK_V   = 19'(HALF_WIDTH);
    localparam logic [18:0] BACK_H   = 19'(HALF_WIDTH * H_RES);

    localparam int              CNT_W      = $clog2(2 * HALF_WIDTH + 1);
    localparam logic [CNT_W-1:0] STAMP_LAST = CNT_W'(2 * HALF_WIDTH);

    logic [1:0]       state;
    logic [18:0]      sweep_addr;
    logic [18:0]      cur_addr;
    logic [18:0]      step_r;
    logic [3:0]       color_r;
    logic             bad_r;
    logic [CNT_W-1:0] stamp_cnt;

    logic [18:0] tail_c;
    logic [18:0] step_c;
    logic [18:0] back_c;
    logic [18:0] start_c;
    logic        bad_c;

    // Tail, strip step and first strip address (k = -HALF_WIDTH) for the presented move.
    always_comb begin
        tail_c = bikeLocation_middle;
        step_c = 19'd1;
        back_c = BACK_V;
        bad_c  = 1'b0;
        case (bike_orient)
            3'd0: tail_c = bikeLocation_middle + V_OFF;
            3'd1: begin
                tail_c = bikeLocation_middle + H_OFF;
                step_c = ROW_STEP;
                back_c = BACK_H;
            end
            3'd2: tail_c = bikeLocation_middle - V_OFF;
            3'd3: begin
                tail_c = bikeLocation_middle - H_OFF;
                step_c = ROW_STEP;
                back_c = BACK_H;
            end
            default: bad_c = 1'b1;
        endcase
        start_c = tail_c - back_c;
    end

    // Sequencer and registered RAM write port; the strip walks from its first
    // address by a fixed step while a down-counter marks the last write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_CLEAR;
            sweep_addr  <= 19'd0;
            cur_addr    <= 19'd0;
            step_r      <= 19'd0;
            color_r     <= 4'd0;
            bad_r       <= 1'b0;
            stamp_cnt   <= '0;
            trail_wren  <= 1'b0;
            trail_waddr <= 19'd0;
            trail_wdata <= 4'd0;
            move_ready  <= 1'b0;
            clear_busy  <= 1'b1;
            stamp_done  <= 1'b0;
        end else begin
            stamp_done <= 1'b0;
            case (state)
                S_CLEAR: begin
                    trail_wren  <= 1'b1;
                    trail_waddr <= sweep_addr;
                    trail_wdata <= 4'd0;
                    clear_busy  <= 1'b1;
                    move_ready  <= 1'b0;
                    if (sweep_addr == ADDR_MAX) begin
                        sweep_addr <= 19'd0;
                        state      <= S_IDLE;
                    end else begin
                        sweep_addr <= sweep_addr + 19'd1;
                    end
                end
                S_IDLE: begin
                    trail_wren <= 1'b0;
                    clear_busy <= 1'b0;
                    move_ready <= master_switch;
                    if (clear_req) begin
                        state      <= S_CLEAR;
                        sweep_addr <= 19'd0;
                        clear_busy <= 1'b1;
                        move_ready <= 1'b0;
                    end else if (move_valid && move_ready) begin
                        state      <= S_STAMP;
                        cur_addr   <= start_c;
                        step_r     <= step_c;
                        bad_r      <= bad_c;
                        color_r    <= player_color;
                        stamp_cnt  <= STAMP_LAST;
                        move_ready <= 1'b0;
                    end
                end
                S_STAMP: begin
                    // Addresses past the end, including wrapped underflow, are skipped but still cost a cycle.
                    trail_wren  <= !bad_r && (cur_addr <= ADDR_MAX);
                    trail_waddr <= cur_addr;
                    trail_wdata <= color_r;
                    cur_addr    <= cur_addr + step_r;
                    move_ready  <= 1'b0;
                    if (stamp_cnt == '0) begin
                        stamp_done <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        stamp_cnt <= stamp_cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= S_CLEAR;
                    sweep_addr <= 19'd0;
                    trail_wren <= 1'b0;
                    clear_busy <= 1'b1;
                    move_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trail_writer.sv
// Bench for trail_writer, using a reduced screen height so each clear sweep is short.
module tb_trail_writer;

    localparam int H    = 640;
    localparam int V    = 20;
    localparam int TOFF = 16;
    localparam int HW   = 4;
    localparam int NPIX = H * V;

    logic        clock;
    logic        reset;
    logic        master_switch;
    logic        clear_req;
    logic        move_valid;
    logic        move_ready;
    logic [18:0] bikeLocation_middle;
    logic [2:0]  bike_orient;
    logic [3:0]  player_color;
    logic        trail_wren;
    logic [18:0] trail_waddr;
    logic [3:0]  trail_wdata;
    logic        clear_busy;
    logic        stamp_done;

    int n_checks = 0;
    int n_fail   = 0;

    trail_writer #(.H_RES(H), .V_RES(V), .TAIL_OFFSET(TOFF), .HALF_WIDTH(HW)) dut (
        .clock               (clock),
        .reset               (reset),
        .master_switch       (master_switch),
        .clear_req           (clear_req),
        .move_valid          (move_valid),
        .move_ready          (move_ready),
        .bikeLocation_middle (bikeLocation_middle),
        .bike_orient         (bike_orient),
        .player_color        (player_color),
        .trail_wren          (trail_wren),
        .trail_waddr         (trail_waddr),
        .trail_wdata         (trail_wdata),
        .clear_busy          (clear_busy),
        .stamp_done          (stamp_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: pixel k of the strip, straight from the tail/step rules, mod 2^19.
    function automatic int model_addr(int mid, int orient, int k);
        int tail;
        int step;
        case (orient)
            0: begin tail = mid + TOFF * H; step = 1; end
            1: begin tail = mid + TOFF;     step = H; end
            2: begin tail = mid - TOFF * H; step = 1; end
            3: begin tail = mid - TOFF;     step = H; end
            default: begin tail = mid; step = 1; end
        endcase
        return ((tail + k * step) % 524288 + 524288) % 524288;
    endfunction

    task automatic test_reset();
        reset = 1'b1; master_switch = 1'b1; clear_req = 1'b0; move_valid = 1'b0;
        bikeLocation_middle = '0; bike_orient = '0; player_color = '0;
        tick(); tick(); tick();
        n_checks++;
        if (trail_wren !== 1'b0 || trail_waddr !== 19'd0 || trail_wdata !== 4'd0 ||
            move_ready !== 1'b0 || clear_busy !== 1'b1 || stamp_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wren=%b addr=%0d data=%0d ready=%b busy=%b done=%b, expected 0 0 0 0 1 0",
                     trail_wren, trail_waddr, trail_wdata, move_ready, clear_busy, stamp_done);
        end
        reset = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            tick();
            n_checks++;
            if (trail_wren !== 1'b1 || trail_waddr !== 19'(i) || trail_wdata !== 4'd0 ||
                clear_busy !== 1'b1 || move_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_sweep: cycle %0d got wren=%b addr=%0d data=%0d busy=%b ready=%b, expected 1 %0d 0 1 0",
                         i + 1, trail_wren, trail_waddr, trail_wdata, clear_busy, move_ready, i);
            end
        end
        tick();
        n_checks++;
        if (trail_wren !== 1'b0 || clear_busy !== 1'b0 || move_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_sweep_end: got wren=%b busy=%b ready=%b, expected 0 0 1",
                     trail_wren, clear_busy, move_ready);
        end
    endtask

    // One move: accept, check the 9 strip cycles against the model, then the return to IDLE.
    task automatic test_stamp(input int mid, input int orient, input int color, input bit drop_switch);
        int  a;
        bit  en;
        int  waits;
        waits = 0;
        while (move_ready !== 1'b1 && waits < 4) begin
            tick();
            waits++;
        end
        n_checks++;
        if (move_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stamp_ready_wait: got ready=%b, expected 1", move_ready);
        end
        move_valid = 1'b1;
        bikeLocation_middle = 19'(mid);
        bike_orient = 3'(orient);
        player_color = 4'(color);
        tick();
        n_checks++;
        if (move_ready !== 1'b0 || trail_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL stamp_accept: got ready=%b wren=%b, expected 0 0", move_ready, trail_wren);
        end
        if (drop_switch) master_switch = 1'b0;
        for (int k = -HW; k <= HW; k++) begin
            move_valid = 1'($urandom);
            bikeLocation_middle = 19'($urandom);
            bike_orient = 3'($urandom);
            player_color = 4'($urandom);
            tick();
            a  = model_addr(mid, orient, k);
            en = (orient < 4) && (a < NPIX);
            n_checks++;
            if (trail_wren !== en || (en && (trail_waddr !== 19'(a) || trail_wdata !== 4'(color))) ||
                stamp_done !== (k == HW) || move_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stamp_write: mid=%0d orient=%0d k=%0d got wren=%b addr=%0d data=%0d done=%b ready=%b, expected %b %0d %0d %b 0",
                         mid, orient, k, trail_wren, trail_waddr, trail_wdata, stamp_done, move_ready,
                         en, a, color, (k == HW));
            end
        end
        tick();
        n_checks++;
        if (trail_wren !== 1'b0 || stamp_done !== 1'b0 || move_ready !== master_switch) begin
            n_fail++;
            $display("FAIL stamp_return: got wren=%b done=%b ready=%b, expected 0 0 %b",
                     trail_wren, stamp_done, move_ready, master_switch);
        end
        move_valid = 1'b0;
        master_switch = 1'b1;
    endtask

    task automatic test_directed_stamps();
        test_stamp(1300, 0, 5, 1'b0);    // up: 11536..11544
        test_stamp(5000, 1, 9, 1'b0);    // left: 2456..7576 step 640
        test_stamp(12000, 2, 3, 1'b0);   // down: 1756..1764
        test_stamp(5000, 3, 12, 1'b0);   // right: 2424..7544 step 640
        test_stamp(3500, 2, 7, 1'b0);    // underflow, all suppressed
        test_stamp(2600, 0, 7, 1'b0);    // tail past end, all suppressed
        test_stamp(2556, 0, 4, 1'b0);    // last pixel just past the end
        test_stamp(1000, 3, 2, 1'b0);    // first three wrap below zero
        test_stamp(5000, 6, 15, 1'b0);   // bad orientation
        test_stamp(6400, 1, 1, 1'b1);    // switch dropped mid-stamp
    endtask

    task automatic test_random_stamps();
        for (int n = 0; n < 30; n++) begin
            test_stamp(int'($urandom_range(0, NPIX + 2000)), int'($urandom_range(0, 7)),
                       int'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_acceptance();
        master_switch = 1'b0;
        tick();
        n_checks++;
        if (move_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL switch_off_ready: got %b, expected 0", move_ready);
        end
        move_valid = 1'b1;
        bikeLocation_middle = 19'd1300;
        bike_orient = 3'd0;
        player_color = 4'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (trail_wren !== 1'b0 || move_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL switch_off_move: cycle %0d got wren=%b ready=%b, expected 0 0",
                         i, trail_wren, move_ready);
            end
        end
        move_valid = 1'b0;
        master_switch = 1'b1;
        tick();
        n_checks++;
        if (move_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_on_ready: got %b, expected 1", move_ready);
        end
    endtask

    task automatic test_clear_priority();
        clear_req = 1'b1;
        move_valid = 1'b1;
        bikeLocation_middle = 19'd1300;
        bike_orient = 3'd0;
        player_color = 4'd5;
        tick();
        clear_req = 1'b0;
        move_valid = 1'b0;
        n_checks++;
        if (trail_wren !== 1'b0 || clear_busy !== 1'b1 || move_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_req_start: got wren=%b busy=%b ready=%b, expected 0 1 0",
                     trail_wren, clear_busy, move_ready);
        end
        for (int i = 0; i < NPIX; i++) begin
            tick();
            n_checks++;
            if (trail_wren !== 1'b1 || trail_waddr !== 19'(i) || trail_wdata !== 4'd0 ||
                clear_busy !== 1'b1 || stamp_done !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_req_sweep: cycle %0d got wren=%b addr=%0d data=%0d busy=%b done=%b, expected 1 %0d 0 1 0",
                         i + 1, trail_wren, trail_waddr, trail_wdata, clear_busy, stamp_done, i);
            end
        end
        tick();
        n_checks++;
        if (trail_wren !== 1'b0 || clear_busy !== 1'b0 || move_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_req_end: got wren=%b busy=%b ready=%b, expected 0 0 1",
                     trail_wren, clear_busy, move_ready);
        end
    endtask

    task automatic test_reset_mid_stamp();
        move_valid = 1'b1;
        bikeLocation_middle = 19'd1300;
        bike_orient = 3'd0;
        player_color = 4'd6;
        tick();                               // edge T
        move_valid = 1'b0;
        tick(); tick(); tick(); tick();       // edges T+1..T+4
        reset = 1'b1;
        tick();                               // edge T+5
        reset = 1'b0;
        n_checks++;
        if (trail_wren !== 1'b0 || clear_busy !== 1'b1 || move_ready !== 1'b0 || stamp_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_stamp: got wren=%b busy=%b ready=%b done=%b, expected 0 1 0 0",
                     trail_wren, clear_busy, move_ready, stamp_done);
        end
        for (int i = 0; i < NPIX; i++) begin
            tick();
            n_checks++;
            if (trail_wren !== 1'b1 || trail_waddr !== 19'(i) || trail_wdata !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_mid_sweep: cycle %0d got wren=%b addr=%0d data=%0d, expected 1 %0d 0",
                         i + 1, trail_wren, trail_waddr, trail_wdata, i);
            end
        end
        tick();
        n_checks++;
        if (trail_wren !== 1'b0 || clear_busy !== 1'b0 || move_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_end: got wren=%b busy=%b ready=%b, expected 0 0 1",
                     trail_wren, clear_busy, move_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed_stamps();
        test_acceptance();
        test_random_stamps();
        test_clear_priority();
        test_stamp(1300, 0, 5, 1'b0);
        test_reset_mid_stamp();
        test_stamp(5000, 1, 9, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/trail_writer.md
# trail_writer

Writes each bike's trail into the 640x480, 4-bit-per-pixel trail memory that the collision logic reads back at the VGA scan address. On every accepted move it stamps a strip of pixels (`2*HALF_WIDTH+1` wide) perpendicular to the direction of travel, behind the bike's tail. It also sweeps the whole memory to zero after reset or on request. It sits between the bike movement controller and the write port of the trail RAM, one instance per player.

## Interface
- `H_RES`, 640: pixels per row; address = y*H_RES + x.
- `V_RES`, 480: rows; valid addresses are 0 .. H_RES*V_RES-1 (0..307199).
- `TAIL_OFFSET`, 16: distance in pixels from the bike middle to its tail.
- `HALF_WIDTH`, 4: strip half-width; each stamp is 2*HALF_WIDTH+1 pixels.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `master_switch`  in  1  game enable; when low, moves are not accepted.
- `clear_req`  in  1  request a full memory clear; sampled only in IDLE.
- `move_valid`  in  1  a new bike position is presented.
- `move_ready`  out  1  registered; high only in IDLE while `master_switch`=1.
- `bikeLocation_middle`  in  19  bike centre address, sampled on acceptance.
- `bike_orient`  in  3  direction code: 0 up, 1 left, 2 down, 3 right; sampled on acceptance.
- `player_color`  in  4  trail code written during a stamp; nonzero by convention.
- `trail_wren`  out  1  registered write enable to the trail RAM.
- `trail_waddr`  out  19  registered write address.
- `trail_wdata`  out  4  registered write data.
- `clear_busy`  out  1  registered; high while the CLEAR sweep runs.
- `stamp_done`  out  1  registered one-cycle pulse on the last stamp write cycle.

## Operation
- The block has three states: CLEAR, IDLE and STAMP.
- **Reset:** reset forces state CLEAR with sweep counter 0.
  - Output values while reset is high: `trail_wren`=0, `trail_waddr`=0, `trail_wdata`=0, `move_ready`=0, `clear_busy`=1, `stamp_done`=0.
- **CLEAR:** writes 0 to addresses 0..307199, one address per cycle, with `trail_wren`=1.
  - After address 307199 the block goes to IDLE.
  - `clear_busy`=1 and `move_ready`=0 throughout.
- **IDLE:** `trail_wren`=0.
  - If `clear_req`=1, go to CLEAR. `clear_req` has priority over `move_valid` in the same cycle.
  - Otherwise, a move is accepted when `move_valid` and `move_ready` are both 1. The block latches position, orientation and `player_color`, then goes to STAMP.
- **Tail address** (all arithmetic mod 2^19, unsigned):
  - up: tail = middle + TAIL_OFFSET*H_RES; step = +1
  - left: tail = middle + TAIL_OFFSET; step = +H_RES
  - down: tail = middle − TAIL_OFFSET*H_RES; step = +1
  - right: tail = middle − TAIL_OFFSET; step = +H_RES
- **STAMP:** a counter k runs from −HALF_WIDTH to +HALF_WIDTH, one value per cycle.
  - Each cycle drives `trail_waddr` = tail + k*step and `trail_wdata` = latched color.
  - **Out-of-range suppression:** `trail_wren`=1 only if the computed address is ≤ 307199. Otherwise `trail_wren`=0, but that cycle is still consumed. Underflow wraps mod 2^19 to a value ≥ 307200, so underflowed addresses are suppressed too.
  - **Bad orientation:** codes 4–7 are accepted, but all 9 writes are suppressed.
  - **Row wrap:** crossing a row boundary is not guarded. The game logic keeps bikes at least 20 px from the left and right edges.
  - After k=+HALF_WIDTH the block returns to IDLE.
- `master_switch` falling during STAMP or CLEAR does not abort the operation.

## Timing
- **Move acceptance:** a move is accepted at edge T.
  - Stamp writes k=−4..+4 appear on edges T+1..T+9.
  - `stamp_done`=1 during the T+9 cycle.
  - At edge T+10: `trail_wren`=0 and `move_ready`=1.
  - Total stamp cost: 9 cycles of writing plus 1 cycle back in IDLE.
- **Clear sweep:** the first edge with reset low presents address 0. Address 307199 is presented on the 307200th edge. The next edge gives IDLE: `clear_busy`=0, and `move_ready`=`master_switch`.
- **`clear_req` from IDLE:** same sweep timing. The first write (address 0) is on the edge after `clear_req` is sampled.
- **Reset mid-operation:** reset mid-STAMP or mid-CLEAR takes effect on the next edge. It drops `trail_wren` and restarts CLEAR from address 0. The interrupted stamp is discarded.
- **Ignored inputs:** `move_valid` while `move_ready`=0 is ignored; the block does not queue it.

## Test plan
- **Reset and clear sweep:** release reset → `trail_wren`=1 with addresses 0,1,2,… of data 0; address 307199 at cycle 307200; then `clear_busy`=0 and `move_ready`=1.
- **Up stamp:** middle=64200, orient=0, color=5 → writes at 74436..74444 (step 1), data 5, on edges T+1..T+9; `stamp_done` at T+9; `move_ready` at T+10.
- **Left stamp:** middle=64200, orient=1 → writes 61656, 62296, …, 66776 (step 640).
- **Out-of-range:** middle=3500 with orient=2 → all 9 cycles have `trail_wren`=0 (underflow); middle=300900 with orient=0 → all suppressed (tail 311140); orient=6 → all suppressed; in each case `move_ready` returns at T+10.
- **Acceptance rules:** `master_switch`=0 with `move_valid`=1 → no acceptance and no writes; `clear_req` and `move_valid` together in IDLE → CLEAR starts and the move is ignored.
- **Reset mid-stamp:** reset at T+5 → `trail_wren`=0 on the next edge, then the sweep restarts at address 0.
